// File: rtl/regs_sd_pkg.sv
// Shared constants and types for the SD register-bank arbiter.
package regs_sd_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic OWN_H    = 1'b0;
  localparam logic OWN_E    = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/regs_sd_arbiter_rr.sv
// Combinational 2-way round-robin picker: a tie goes to whoever did not own last.
module regs_arb_rr
  import regs_sd_pkg::*;
(
  input  logic h_req_i,
  input  logic e_req_i,
  input  logic last_owner_i,
  output logic grant_valid_o,
  output logic grant_owner_o
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid_o = h_req_i | e_req_i;
    grant_owner_o = OWN_H;
    if (h_req_i && e_req_i) begin
      grant_owner_o = (last_owner_i == OWN_H) ? OWN_E : OWN_H;
    end else if (e_req_i) begin
      grant_owner_o = OWN_E;
    end
  end

endmodule

// File: rtl/regs_sd_arbiter.sv
// Serialises host (H) and engine (E) accesses onto the single-port SD register bank.
// Optional bank-ack watchdog with h_err/e_err outputs: define REGS_ARB_TIMEOUT_EN.
module regs_sd_arbiter #(
  parameter int DATA_W         = regs_sd_pkg::DATA_W,
`ifdef REGS_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 16,
`endif
  parameter int ADDR_W         = regs_sd_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_rw,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_data_in,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_data_out,
  input  logic              e_req,
  input  logic              e_rw,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_data_in,
  output logic              e_ack,
  output logic [DATA_W-1:0] e_data_out,
`ifdef REGS_ARB_TIMEOUT_EN
  output logic              h_err,
  output logic              e_err,
`endif
  output logic              r_req,
  output logic              r_rw,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data_in,
  input  logic              r_ack,
  input  logic [DATA_W-1:0] r_data_out,
  output logic              busy,
  output logic              owner
);

  import regs_sd_pkg::*;

  state_e            state_q;
  logic              last_owner_q;
  logic              owner_q;
  logic              r_req_q;
  logic              r_rw_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_data_in_q;
  logic              h_ack_q;
  logic              e_ack_q;
  logic [DATA_W-1:0] h_data_out_q;
  logic [DATA_W-1:0] e_data_out_q;
  logic              grant_valid;
  logic              grant_owner;
  logic              timeout_hit;

`ifdef REGS_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;
  logic       h_err_q;
  logic       e_err_q;
  assign timeout_hit = (tmo_cnt_q == TIMEOUT_LAST);
  assign h_err       = h_err_q;
  assign e_err       = e_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  regs_arb_rr u_rr (
    .h_req_i       (h_req),
    .e_req_i       (e_req),
    .last_owner_i  (last_owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_E;
      owner_q      <= OWN_H;
      r_req_q      <= 1'b0;
      r_rw_q       <= RW_WRITE;
      r_addr_q     <= '0;
      r_data_in_q  <= '0;
      h_ack_q      <= 1'b0;
      e_ack_q      <= 1'b0;
      h_data_out_q <= '0;
      e_data_out_q <= '0;
`ifdef REGS_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      h_err_q      <= 1'b0;
      e_err_q      <= 1'b0;
`endif
    end else begin
      h_ack_q <= 1'b0;
      e_ack_q <= 1'b0;
`ifdef REGS_ARB_TIMEOUT_EN
      h_err_q <= 1'b0;
      e_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // r_ack is deliberately not looked at here, so a spurious bank ack is ignored.
          if (grant_valid) begin
            owner_q     <= grant_owner;
            r_req_q     <= 1'b1;
            r_rw_q      <= (grant_owner == OWN_E) ? e_rw      : h_rw;
            r_addr_q    <= (grant_owner == OWN_E) ? e_addr    : h_addr;
            r_data_in_q <= (grant_owner == OWN_E) ? e_data_in : h_data_in;
`ifdef REGS_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_ack || timeout_hit) begin
            r_req_q      <= 1'b0;
            last_owner_q <= owner_q;
            state_q      <= RELEASE;
            if (owner_q == OWN_E) e_ack_q <= 1'b1;
            else                  h_ack_q <= 1'b1;
            if (r_ack && (r_rw_q == RW_READ)) begin
              if (owner_q == OWN_E) e_data_out_q <= r_data_out;
              else                  h_data_out_q <= r_data_out;
            end
`ifdef REGS_ARB_TIMEOUT_EN
            if (!r_ack) begin
              if (owner_q == OWN_E) e_err_q <= 1'b1;
              else                  h_err_q <= 1'b1;
            end
`endif
          end
`ifdef REGS_ARB_TIMEOUT_EN
          else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        RELEASE: begin
          if (!r_ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_req      = r_req_q;
  assign r_rw       = r_rw_q;
  assign r_addr     = r_addr_q;
  assign r_data_in  = r_data_in_q;
  assign h_ack      = h_ack_q;
  assign e_ack      = e_ack_q;
  assign h_data_out = h_data_out_q;
  assign e_data_out = e_data_out_q;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_regs_sd_arbiter.sv
// Scoreboard bench for regs_sd_arbiter: requester drivers push expectations, an ack monitor checks them.
`timescale 1ns/1ps
module tb_regs_sd_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          h_req, h_rw, h_ack;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data_in, h_data_out;
  logic          e_req, e_rw, e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data_in, e_data_out;
  logic          r_req, r_rw, r_ack;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data_in, r_data_out;
  logic          busy, owner;
`ifdef REGS_ARB_TIMEOUT_EN
  logic          h_err, e_err;
`endif

  always #5 clk = ~clk;

  regs_sd_arbiter #(
    .DATA_W(DW),
`ifdef REGS_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(TMO),
`endif
    .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .h_req(h_req), .h_rw(h_rw), .h_addr(h_addr), .h_data_in(h_data_in),
    .h_ack(h_ack), .h_data_out(h_data_out),
    .e_req(e_req), .e_rw(e_rw), .e_addr(e_addr), .e_data_in(e_data_in),
    .e_ack(e_ack), .e_data_out(e_data_out),
`ifdef REGS_ARB_TIMEOUT_EN
    .h_err(h_err), .e_err(e_err),
`endif
    .r_req(r_req), .r_rw(r_rw), .r_addr(r_addr), .r_data_in(r_data_in),
    .r_ack(r_ack), .r_data_out(r_data_out),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bank_t;

  int            checks   = 0;
  int            failures = 0;
  exp_t          h_q[$];
  exp_t          e_q[$];
  bank_t         bank_log[$];
  bit            ack_log[$];
  logic [DW-1:0] ref_mem  [32];
  logic [DW-1:0] bank_mem [32];
  logic [DW-1:0] last_rd  [2];

  int bank_delay = 2;
  int bank_hold  = 0;
  bit bank_rand  = 1'b0;
  bit bank_never = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Bank: acks after a programmable delay, holds r_ack for a programmable time after r_req drops.
  initial begin
    int phase, cnt, d, hd;
    phase = 0; cnt = 0; d = 0; hd = 0;
    r_ack = 1'b0;
    r_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        phase = 0;
        r_ack = 1'b0;
      end else begin
        case (phase)
          0: if (r_req) begin
            cnt   = 0;
            d     = bank_rand ? int'($urandom_range(1, 4)) : bank_delay;
            hd    = bank_rand ? int'($urandom_range(0, 3)) : bank_hold;
            phase = 1;
          end
          1: if (!r_req) begin
            phase = 0;
          end else begin
            check("busy_in_issue", busy, 1);
            cnt++;
            if (!bank_never && cnt >= d) begin
              bank_log.push_back('{r_rw, r_addr, r_data_in});
              if (r_rw) begin
                r_data_out = bank_mem[r_addr];
              end else begin
                bank_mem[r_addr] = r_data_in;
                r_data_out = $urandom;
              end
              r_ack = 1'b1;
              phase = 2;
            end
          end
          2: if (!r_req) begin
            if (hd == 0) begin
              r_ack = 1'b0;
              phase = 0;
            end else begin
              cnt   = 0;
              phase = 3;
            end
          end
          default: begin
            check("r_req_low_until_release", r_req, 0);
            check("busy_in_release", busy, 1);
            cnt++;
            if (cnt >= hd) begin
              r_ack = 1'b0;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic score(input bit who);
    exp_t  x;
    bank_t b;
    string tag = who ? "e" : "h";
    if ((who ? e_q.size() : h_q.size()) == 0) begin
      fail_now({tag, "_unexpected_ack"}, "got ack=1 expected ack=0");
      return;
    end
    if (who) x = e_q.pop_front();
    else     x = h_q.pop_front();
    ack_log.push_back(who);
    check({tag, "_owner"}, owner, who);
    check({tag, "_data_out"}, who ? e_data_out : h_data_out, x.rdata);
`ifdef REGS_ARB_TIMEOUT_EN
    check({tag, "_err"}, who ? e_err : h_err, x.err);
`endif
    if (!x.err) begin
      if (bank_log.size() == 0) begin
        fail_now({tag, "_bank_access"}, "got no bank access expected one");
      end else begin
        b = bank_log.pop_front();
        check({tag, "_bank_rw"}, b.rw, x.rw);
        check({tag, "_bank_addr"}, b.addr, x.addr);
        if (!x.rw) check({tag, "_bank_wdata"}, b.wdata, x.wdata);
      end
      if (!x.rw) ref_mem[x.addr] = x.wdata;
    end
  endtask

  bit h_ack_prev = 1'b0;
  bit e_ack_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      h_ack_prev = 1'b0;
      e_ack_prev = 1'b0;
    end else begin
      if (h_ack_prev) check("h_ack_single_pulse", h_ack, 0);
      if (e_ack_prev) check("e_ack_single_pulse", e_ack, 0);
      if (h_ack) score(1'b0);
      if (e_ack) score(1'b1);
      h_ack_prev = h_ack;
      e_ack_prev = e_ack;
    end
  end

  task automatic drive(input bit who, input bit req, input bit rw,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (who) begin
      e_req = req; e_rw = rw; e_addr = addr; e_data_in = wd;
    end else begin
      h_req = req; h_rw = rw; h_addr = addr; h_data_in = wd;
    end
  endtask

  task automatic push_exp(input bit who, input bit rw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input bit err);
    exp_t x;
    x.rw = rw; x.addr = addr; x.wdata = wd; x.err = err;
    if (rw && !err) last_rd[who] = ref_mem[addr];
    x.rdata = last_rd[who];
    if (who) e_q.push_back(x);
    else     h_q.push_back(x);
  endtask

  // One four-phase transaction; lat = negedges from raising req to seeing ack.
  task automatic txn(input bit who, input bit rw, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit err, output int lat);
    bit got = 1'b0;
    @(negedge clk);
    push_exp(who, rw, addr, wd, err);
    drive(who, 1'b1, rw, addr, wd);
    lat = 0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      got = who ? e_ack : h_ack;
    end
    if (!got) fail_now(who ? "e_ack_wait" : "h_ack_wait", "got no ack within 300 cycles");
    drive(who, 1'b0, rw, addr, wd);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || r_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || r_ack) fail_now("idle_wait", "got busy after 100 cycles expected idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    h_q.delete(); e_q.delete(); bank_log.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, lat_h, lat_e, acks;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0; last_rd[1] = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]  = $urandom;
      bank_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_r_req", r_req, 0);
    check("rst_r_rw", r_rw, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_r_data_in", r_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_h_ack", h_ack, 0);
    check("rst_e_ack", e_ack, 0);
    check("rst_h_data_out", h_data_out, 0);
    check("rst_e_data_out", e_data_out, 0);
    reset = 1'b0;

    // Host write, bank acks 3 cycles after r_req.
    bank_delay = 3; bank_hold = 0;
    fork
      txn(1'b0, 1'b0, 5'h04, 32'h01010001, 1'b0, lat);
      begin
        repeat (2) @(negedge clk);
        check("hw_r_req_latency", r_req, 1);
        check("hw_r_rw", r_rw, 0);
        check("hw_r_addr", r_addr, 5'h04);
        check("hw_r_data_in", r_data_in, 32'h01010001);
      end
    join
    check("hw_ack_latency", lat, 5);
    wait_idle();

    // Engine read.
    bank_delay = 2;
    bank_mem[5'h16] = 32'h11011010;
    ref_mem[5'h16]  = 32'h11011010;
    txn(1'b1, 1'b1, 5'h16, '0, 1'b0, lat);
    check("er_ack_latency", lat, 4);
    wait_idle();

    // Tie after reset: both held, grants must alternate H, E, H, E.
    do_reset();
    ack_log.delete();
    bank_delay = 1;
    @(negedge clk);
    push_exp(1'b0, 1'b1, 5'h03, '0, 1'b0);
    push_exp(1'b1, 1'b1, 5'h14, '0, 1'b0);
    push_exp(1'b0, 1'b1, 5'h03, '0, 1'b0);
    push_exp(1'b1, 1'b1, 5'h14, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'h03, '0);
    drive(1'b1, 1'b1, 1'b1, 5'h14, '0);
    acks = 0;
    for (int n = 0; n < 200 && acks < 4; n++) begin
      @(negedge clk);
      acks += int'(h_ack) + int'(e_ack);
    end
    drive(1'b0, 1'b0, 1'b1, 5'h03, '0);
    drive(1'b1, 1'b0, 1'b1, 5'h14, '0);
    wait_idle();
    check("tie_ack_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++)
      check($sformatf("tie_order_%0d", i), ack_log[i], i % 2);

    // Slow release with the engine waiting behind the host.
    bank_delay = 2; bank_hold = 4;
    fork
      txn(1'b0, 1'b0, 5'h09, $urandom, 1'b0, lat);
      begin
        @(negedge clk);
        txn(1'b1, 1'b1, 5'h13, '0, 1'b0, lat2);
      end
    join
    wait_idle();
    bank_hold = 0;

    // Reset two cycles into ISSUE: transaction lost, no ack.
    bank_delay = 10;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 5'h05, 32'hDEAD_BEEF);
    for (int n = 0; n < 20 && !r_req; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_r_req", r_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_h_ack", h_ack, 0);
    do_reset();
    bank_delay = 2;
    txn(1'b0, 1'b1, 5'h05, '0, 1'b0, lat);
    check("midrst_rearb_latency", lat, 4);
    wait_idle();

    // Randomized concurrent traffic on disjoint address halves.
    bank_rand = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        txn(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom, 1'b0, lat_h);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        txn(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)), $urandom, 1'b0, lat_e);
      end
    join
    bank_rand = 1'b0;
    wait_idle();

`ifdef REGS_ARB_TIMEOUT_EN
    // Bank never acks: watchdog completes the host read with an error.
    bank_never = 1'b1;
    txn(1'b0, 1'b1, 5'h02, '0, 1'b1, lat);
    check("tmo_ack_latency", lat, TMO + 1);
    bank_never = 1'b0;
    wait_idle();
    txn(1'b0, 1'b1, 5'h02, '0, 1'b0, lat);
    wait_idle();
`endif

    check("h_queue_drained", h_q.size(), 0);
    check("e_queue_drained", e_q.size(), 0);
    check("bank_log_drained", bank_log.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
